// File: rtl/gray_to_binary_tracker.sv
// Gray-to-binary receiver: two-stage conversion pipeline with step tracking,
// illegal multi-bit transition detection and a saturating error counter.
module gray_to_binary_tracker #(
  parameter int WIDTH     = 4,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     gray_in,
  input  logic                 gray_valid,
  input  logic                 clear,
  output logic [WIDTH-1:0]     bin_out,
  output logic                 bin_valid,
  output logic [WIDTH-1:0]     step,
  output logic                 step_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  typedef enum logic {EMPTY = 1'b0, TRACK = 1'b1} hist_state_t;

  hist_state_t          state_reg, state_next;
  logic [WIDTH-1:0]     g1_reg;
  logic                 v1_reg;
  logic [WIDTH-1:0]     prev_gray_reg, prev_gray_next;
  logic [WIDTH-1:0]     prev_bin_reg, prev_bin_next;
  logic [WIDTH-1:0]     bin_reg, bin_next;
  logic                 bin_valid_reg, bin_valid_next;
  logic [WIDTH-1:0]     step_reg, step_next;
  logic                 step_err_reg, step_err_next;
  logic [ERR_CNT_W-1:0] err_count_reg, err_count_next;

  logic [WIDTH-1:0]     conv_bin;
  logic [WIDTH-1:0]     gray_diff;
  logic                 multi_bit;

  // Each binary bit is the XOR of all Gray bits at or above it.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_conv
      assign conv_bin[gi] = ^g1_reg[WIDTH-1:gi];
    end
  endgenerate

  // More than one bit set in the difference means an illegal Gray jump.
  assign gray_diff = g1_reg ^ prev_gray_reg;
  assign multi_bit = (gray_diff & (gray_diff - WIDTH'(1))) != '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      g1_reg <= '0;
      v1_reg <= 1'b0;
    end else if (clear) begin
      v1_reg <= 1'b0;
    end else begin
      v1_reg <= gray_valid;
      if (gray_valid) g1_reg <= gray_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= EMPTY;
      prev_gray_reg <= '0;
      prev_bin_reg  <= '0;
      bin_reg       <= '0;
      bin_valid_reg <= 1'b0;
      step_reg      <= '0;
      step_err_reg  <= 1'b0;
      err_count_reg <= '0;
    end else begin
      state_reg     <= state_next;
      prev_gray_reg <= prev_gray_next;
      prev_bin_reg  <= prev_bin_next;
      bin_reg       <= bin_next;
      bin_valid_reg <= bin_valid_next;
      step_reg      <= step_next;
      step_err_reg  <= step_err_next;
      err_count_reg <= err_count_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    prev_gray_next = prev_gray_reg;
    prev_bin_next  = prev_bin_reg;
    bin_next       = bin_reg;
    bin_valid_next = 1'b0;
    step_next      = step_reg;
    step_err_next  = 1'b0;
    err_count_next = err_count_reg;
    if (clear) begin
      state_next = EMPTY;
    end else if (v1_reg) begin
      bin_next       = conv_bin;
      bin_valid_next = 1'b1;
      prev_gray_next = g1_reg;
      prev_bin_next  = conv_bin;
      state_next     = TRACK;
      case (state_reg)
        EMPTY: step_next = '0;
        TRACK: begin
          step_next     = conv_bin - prev_bin_reg;
          step_err_next = multi_bit;
        end
        default: step_next = '0;
      endcase
      if (step_err_next && (err_count_reg != {ERR_CNT_W{1'b1}}))
        err_count_next = err_count_reg + ERR_CNT_W'(1);
    end
  end

  assign bin_out   = bin_reg;
  assign bin_valid = bin_valid_reg;
  assign step      = step_reg;
  assign step_err  = step_err_reg;
  assign err_count = err_count_reg;

endmodule

// File: tb/tb_gray_to_binary_tracker.sv
// Randomized and directed checks of gray_to_binary_tracker against a
// behavioural model built from Gray arithmetic and a sample history.
module tb_gray_to_binary_tracker;
  localparam int W = 4;
  localparam int E = 8;
  localparam int MOD = 1 << W;
  localparam int CMAX = (1 << E) - 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] gray_in = '0;
  logic         gray_valid = 1'b0;
  logic         clear = 1'b0;
  logic [W-1:0] bin_out;
  logic         bin_valid;
  logic [W-1:0] step;
  logic         step_err;
  logic [E-1:0] err_count;

  gray_to_binary_tracker #(.WIDTH(W), .ERR_CNT_W(E)) dut (
    .clk(clk), .rst_n(rst_n), .gray_in(gray_in), .gray_valid(gray_valid),
    .clear(clear), .bin_out(bin_out), .bin_valid(bin_valid), .step(step),
    .step_err(step_err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  // Model: one pending sample, last accepted sample, and expected outputs.
  bit     m_pend_v;
  int     m_pend_g;
  bit     m_have_prev;
  int     m_prev_g, m_prev_b;
  int     m_bin, m_step, m_cnt;
  bit     m_valid, m_err;

  function automatic int g2b(input int g);
    int b = 0;
    int x = g;
    while (x != 0) begin
      b = b ^ x;
      x = x >> 1;
    end
    return b;
  endfunction

  function automatic logic [17:0] exp_vec();
    return {m_valid, W'(m_bin), W'(m_step), m_err, E'(m_cnt)};
  endfunction

  task automatic model_reset();
    m_pend_v = 0; m_pend_g = 0; m_have_prev = 0; m_prev_g = 0; m_prev_b = 0;
    m_bin = 0; m_step = 0; m_cnt = 0; m_valid = 0; m_err = 0;
  endtask

  task automatic model_edge(input bit v, input int g, input bit c);
    int b;
    if (c) begin
      m_valid = 0; m_err = 0; m_have_prev = 0; m_pend_v = 0;
    end else begin
      if (m_pend_v) begin
        b = g2b(m_pend_g);
        m_bin = b;
        m_valid = 1;
        if (m_have_prev) begin
          m_step = (b - m_prev_b + MOD) % MOD;
          m_err = $countones(m_pend_g ^ m_prev_g) > 1;
        end else begin
          m_step = 0;
          m_err = 0;
        end
        if (m_err && m_cnt < CMAX) m_cnt = m_cnt + 1;
        m_prev_g = m_pend_g; m_prev_b = b; m_have_prev = 1;
      end else begin
        m_valid = 0; m_err = 0;
      end
      m_pend_v = v; m_pend_g = g;
    end
  endtask

  task automatic drive_cycle(input bit v, input int g, input bit c);
    gray_valid = v; gray_in = W'(g); clear = c;
    @(posedge clk); #1;
    model_edge(v, g, c);
    gray_valid = 1'b0; clear = 1'b0;
    if (bin_valid)
      $display("[TB] out bin=%0d step=%0d err=%0b cnt=%0d", bin_out, step, step_err, err_count);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; gray_valid = 1'b0; clear = 1'b0;
    #2;
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; #2;
    model_reset();
    tests_run++;
    if ({bin_valid, bin_out, step, step_err, err_count} !== 18'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs got %h expected 0", {bin_valid, bin_out, step, step_err, err_count});
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_sequence();
    int seq[5] = '{0, 1, 3, 2, 6};
    int eb[5] = '{0, 1, 2, 3, 4};
    int es[5] = '{0, 1, 1, 1, 1};
    int n = 0;
    logic [6:0] pat = '0;
    for (int i = 0; i < 7; i++) begin
      drive_cycle(i < 5, (i < 5) ? seq[i] : 0, 0);
      pat[i] = bin_valid;
      tests_run++;
      if ({bin_valid, bin_out, step, step_err, err_count} !== exp_vec()) begin
        tests_failed++;
        $display("FAIL seq_model cyc=%0d got %h expected %h", i, {bin_valid, bin_out, step, step_err, err_count}, exp_vec());
      end
      if (bin_valid && n < 5) begin
        tests_run++;
        if (bin_out !== W'(eb[n]) || step !== W'(es[n]) || step_err !== 1'b0) begin
          tests_failed++;
          $display("FAIL seq_value n=%0d got bin=%0d step=%0d err=%0b expected bin=%0d step=%0d err=0",
                   n, bin_out, step, step_err, eb[n], es[n]);
        end
        n++;
      end
    end
    tests_run++;
    if (pat !== 7'b0111110) begin
      tests_failed++;
      $display("FAIL seq_valid_pattern got %b expected 0111110", pat);
    end
  endtask

  task automatic test_wrap();
    int seq[3] = '{9, 8, 0};
    int eb[3] = '{14, 15, 0};
    int es[3] = '{0, 1, 1};
    int n = 0;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive_cycle(i < 3, (i < 3) ? seq[i] : 0, 0);
      if (bin_valid && n < 3) begin
        tests_run++;
        if (bin_out !== W'(eb[n]) || step !== W'(es[n]) || step_err !== 1'b0) begin
          tests_failed++;
          $display("FAIL wrap n=%0d got bin=%0d step=%0d err=%0b expected bin=%0d step=%0d err=0",
                   n, bin_out, step, step_err, eb[n], es[n]);
        end
        n++;
      end
    end
    tests_run++;
    if (n != 3) begin
      tests_failed++;
      $display("FAIL wrap_count got %0d expected 3", n);
    end
  endtask

  task automatic test_illegal();
    int seq[3] = '{0, 3, 3};
    int eb[3] = '{0, 2, 2};
    int es[3] = '{0, 2, 0};
    bit ee[3] = '{0, 1, 0};
    int n = 0;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive_cycle(i < 3, (i < 3) ? seq[i] : 0, 0);
      if (bin_valid && n < 3) begin
        tests_run++;
        if (bin_out !== W'(eb[n]) || step !== W'(es[n]) || step_err !== ee[n]) begin
          tests_failed++;
          $display("FAIL illegal n=%0d got bin=%0d step=%0d err=%0b expected bin=%0d step=%0d err=%0b",
                   n, bin_out, step, step_err, eb[n], es[n], ee[n]);
        end
        n++;
      end
    end
    tests_run++;
    if (err_count !== E'(1) || n != 3) begin
      tests_failed++;
      $display("FAIL illegal_count got cnt=%0d outs=%0d expected cnt=1 outs=3", err_count, n);
    end
  endtask

  task automatic test_gapped();
    logic [W-1:0] held;
    for (int i = 0; i < 14; i++) begin
      held = bin_out;
      drive_cycle(i % 2 == 0 && i < 12, $urandom_range(MOD - 1), 0);
      tests_run++;
      if ({bin_valid, bin_out, step, step_err, err_count} !== exp_vec()) begin
        tests_failed++;
        $display("FAIL gapped_model cyc=%0d got %h expected %h", i, {bin_valid, bin_out, step, step_err, err_count}, exp_vec());
      end
      if (!bin_valid && i > 0) begin
        tests_run++;
        if (bin_out !== held) begin
          tests_failed++;
          $display("FAIL gapped_hold cyc=%0d got %0d expected %0d", i, bin_out, held);
        end
      end
    end
  endtask

  task automatic test_clear();
    int cnt_before;
    bit saw;
    drive_cycle(1, 3, 0);
    drive_cycle(0, 0, 0);
    drive_cycle(1, 12, 0);
    drive_cycle(0, 0, 1);
    cnt_before = m_cnt;
    drive_cycle(1, 5, 1);
    saw = 0;
    for (int i = 0; i < 3; i++) begin
      drive_cycle(0, 0, 0);
      saw = saw | bin_valid;
    end
    tests_run++;
    if (saw !== 1'b0) begin
      tests_failed++;
      $display("FAIL clear_discard got bin_valid=1 expected 0");
    end
    drive_cycle(1, 7, 0);
    drive_cycle(0, 0, 0);
    tests_run++;
    if (bin_valid !== 1'b1 || bin_out !== W'(5) || step !== W'(0) || step_err !== 1'b0 ||
        err_count !== E'(cnt_before)) begin
      tests_failed++;
      $display("FAIL clear_first got v=%0b bin=%0d step=%0d err=%0b cnt=%0d expected v=1 bin=5 step=0 err=0 cnt=%0d",
               bin_valid, bin_out, step, step_err, err_count, cnt_before);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      drive_cycle($urandom_range(3) != 0, $urandom_range(MOD - 1), $urandom_range(15) == 0);
      tests_run++;
      if ({bin_valid, bin_out, step, step_err, err_count} !== exp_vec()) begin
        tests_failed++;
        $display("FAIL random_model cyc=%0d got %h expected %h", i, {bin_valid, bin_out, step, step_err, err_count}, exp_vec());
      end
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 302; i++) begin
      drive_cycle(i < 300, (i % 2 == 0) ? 0 : 3, 0);
      tests_run++;
      if ({bin_valid, bin_out, step, step_err, err_count} !== exp_vec()) begin
        tests_failed++;
        $display("FAIL sat_model cyc=%0d got %h expected %h", i, {bin_valid, bin_out, step, step_err, err_count}, exp_vec());
      end
    end
    tests_run++;
    if (err_count !== E'(CMAX)) begin
      tests_failed++;
      $display("FAIL sat_value got %0d expected %0d", err_count, CMAX);
    end
    // Async reset between edges while samples are in flight.
    drive_cycle(1, 0, 0);
    gray_valid = 1'b1; gray_in = W'(3);
    @(posedge clk); #3;
    rst_n = 1'b0; #1;
    model_reset();
    tests_run++;
    if ({bin_valid, bin_out, step, step_err, err_count} !== 18'd0) begin
      tests_failed++;
      $display("FAIL async_reset got %h expected 0", {bin_valid, bin_out, step, step_err, err_count});
    end
    gray_valid = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_cycle(i == 0, 10, 0);
      tests_run++;
      if ({bin_valid, bin_out, step, step_err, err_count} !== exp_vec()) begin
        tests_failed++;
        $display("FAIL post_reset cyc=%0d got %h expected %h", i, {bin_valid, bin_out, step, step_err, err_count}, exp_vec());
      end
      if (i == 1) begin
        tests_run++;
        if (bin_valid !== 1'b1 || bin_out !== W'(12) || step !== W'(0)) begin
          tests_failed++;
          $display("FAIL post_reset_first got v=%0b bin=%0d step=%0d expected v=1 bin=12 step=0",
                   bin_valid, bin_out, step);
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_sequence();
    test_wrap();
    test_illegal();
    test_gapped();
    test_clear();
    test_random();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
